// File: rtl/alu_reservation_station_pkg.sv
// Shared constants and helpers for the ALU reservation station.
// Operand-source selection is resolved once here so dispatch bypass and wakeup agree.
package alu_reservation_station_pkg;

    localparam int RS_DEPTH_DEF = 16;
    localparam int TAG_W_DEF    = 4;
    localparam int OP_W_DEF     = 6;
    localparam int DATA_W_DEF   = 32;

    localparam logic [OP_W_DEF-1:0] OP_ADD  = 6'h01;
    localparam logic [OP_W_DEF-1:0] OP_SUB  = 6'h02;
    localparam logic [OP_W_DEF-1:0] OP_ADDI = 6'h0A;
    localparam logic [OP_W_DEF-1:0] OP_BEQ  = 6'h10;
    localparam logic [OP_W_DEF-1:0] OP_JAL  = 6'h18;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LSB  = 2'd2
    } cdb_src_e;

    // The ALU bus wins when both broadcasts carry the awaited tag.
    function automatic cdb_src_e cdb_pick(input logic busy, input logic alu_hit, input logic lsb_hit);
        if (!busy)   return SRC_NONE;
        if (alu_hit) return SRC_ALU;
        if (lsb_hit) return SRC_LSB;
        return SRC_NONE;
    endfunction

endpackage

// File: rtl/alu_reservation_station_prio_enc.sv
// Lowest-index-wins priority encoder: request vector -> index plus found flag.
module rs_prio_enc #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands resolve, then issues
// the lowest-index ready entry per cycle onto registered outputs for the alu stage.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int RS_DEPTH = RS_DEPTH_DEF,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int OP_W     = OP_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dispatch_valid,
    input  logic [OP_W-1:0]   dispatch_op,
    input  logic [DATA_W-1:0] dispatch_imm,
    input  logic [DATA_W-1:0] dispatch_pc,
    input  logic [TAG_W-1:0]  dispatch_tag,
    input  logic              dispatch_q1_busy,
    input  logic [TAG_W-1:0]  dispatch_q1,
    input  logic [DATA_W-1:0] dispatch_v1,
    input  logic              dispatch_q2_busy,
    input  logic [TAG_W-1:0]  dispatch_q2,
    input  logic [DATA_W-1:0] dispatch_v2,
    input  logic              cdb_alu_valid,
    input  logic [TAG_W-1:0]  cdb_alu_tag,
    input  logic [DATA_W-1:0] cdb_alu_data,
    input  logic              cdb_lsb_valid,
    input  logic [TAG_W-1:0]  cdb_lsb_tag,
    input  logic [DATA_W-1:0] cdb_lsb_data,
    input  logic              clear_from_rob,
    output logic              full_to_dispatch,
    output logic [OP_W-1:0]   op_to_alu,
    output logic [DATA_W-1:0] v1_to_alu,
    output logic [DATA_W-1:0] v2_to_alu,
    output logic [DATA_W-1:0] imm_to_alu,
    output logic [DATA_W-1:0] pc_to_alu,
    output logic [TAG_W-1:0]  tag_to_rob,
    output logic              is_empty_to_alu
);

    localparam int IDX_W = $clog2(RS_DEPTH);

    logic [RS_DEPTH-1:0] r_valid;
    logic [RS_DEPTH-1:0] r_q1_busy;
    logic [RS_DEPTH-1:0] r_q2_busy;
    logic [OP_W-1:0]     r_op  [RS_DEPTH];
    logic [DATA_W-1:0]   r_imm [RS_DEPTH];
    logic [DATA_W-1:0]   r_pc  [RS_DEPTH];
    logic [TAG_W-1:0]    r_tag [RS_DEPTH];
    logic [TAG_W-1:0]    r_q1  [RS_DEPTH];
    logic [TAG_W-1:0]    r_q2  [RS_DEPTH];
    logic [DATA_W-1:0]   r_v1  [RS_DEPTH];
    logic [DATA_W-1:0]   r_v2  [RS_DEPTH];

    logic [OP_W-1:0]     r_op_o;
    logic [DATA_W-1:0]   r_v1_o;
    logic [DATA_W-1:0]   r_v2_o;
    logic [DATA_W-1:0]   r_imm_o;
    logic [DATA_W-1:0]   r_pc_o;
    logic [TAG_W-1:0]    r_tag_o;
    logic                r_empty_o;

    logic [RS_DEPTH-1:0] w_ready;
    logic [RS_DEPTH-1:0] w_q1_busy_nxt;
    logic [RS_DEPTH-1:0] w_q2_busy_nxt;
    logic [DATA_W-1:0]   w_v1_nxt [RS_DEPTH];
    logic [DATA_W-1:0]   w_v2_nxt [RS_DEPTH];
    logic [IDX_W-1:0]    w_free_idx;
    logic                w_free_found;
    logic [IDX_W-1:0]    w_rdy_idx;
    logic                w_rdy_found;
    logic                w_full;
    logic                w_do_disp;

    cdb_src_e            w_d_s1;
    cdb_src_e            w_d_s2;
    logic                w_d_q1_busy;
    logic                w_d_q2_busy;
    logic [DATA_W-1:0]   w_d_v1;
    logic [DATA_W-1:0]   w_d_v2;

    assign w_ready   = r_valid & ~r_q1_busy & ~r_q2_busy;
    assign w_full    = &r_valid;
    assign w_do_disp = dispatch_valid && w_free_found;

    rs_prio_enc #(.N(RS_DEPTH), .IDX_W(IDX_W)) u_free_enc (
        .i_req   (~r_valid),
        .o_idx   (w_free_idx),
        .o_found (w_free_found)
    );

    rs_prio_enc #(.N(RS_DEPTH), .IDX_W(IDX_W)) u_rdy_enc (
        .i_req   (w_ready),
        .o_idx   (w_rdy_idx),
        .o_found (w_rdy_found)
    );

    // Dispatch bypass: an operand produced on a CDB this very cycle is stored resolved.
    assign w_d_s1 = cdb_pick(dispatch_q1_busy,
                             cdb_alu_valid && (cdb_alu_tag == dispatch_q1),
                             cdb_lsb_valid && (cdb_lsb_tag == dispatch_q1));
    assign w_d_s2 = cdb_pick(dispatch_q2_busy,
                             cdb_alu_valid && (cdb_alu_tag == dispatch_q2),
                             cdb_lsb_valid && (cdb_lsb_tag == dispatch_q2));
    assign w_d_q1_busy = dispatch_q1_busy && (w_d_s1 == SRC_NONE);
    assign w_d_q2_busy = dispatch_q2_busy && (w_d_s2 == SRC_NONE);
    assign w_d_v1 = (w_d_s1 == SRC_ALU) ? cdb_alu_data :
                    (w_d_s1 == SRC_LSB) ? cdb_lsb_data : dispatch_v1;
    assign w_d_v2 = (w_d_s2 == SRC_ALU) ? cdb_alu_data :
                    (w_d_s2 == SRC_LSB) ? cdb_lsb_data : dispatch_v2;

    for (genvar i = 0; i < RS_DEPTH; i++) begin : g_wake
        cdb_src_e w_s1;
        cdb_src_e w_s2;
        assign w_s1 = cdb_pick(r_valid[i] && r_q1_busy[i],
                               cdb_alu_valid && (cdb_alu_tag == r_q1[i]),
                               cdb_lsb_valid && (cdb_lsb_tag == r_q1[i]));
        assign w_s2 = cdb_pick(r_valid[i] && r_q2_busy[i],
                               cdb_alu_valid && (cdb_alu_tag == r_q2[i]),
                               cdb_lsb_valid && (cdb_lsb_tag == r_q2[i]));
        assign w_q1_busy_nxt[i] = r_q1_busy[i] && (w_s1 == SRC_NONE);
        assign w_q2_busy_nxt[i] = r_q2_busy[i] && (w_s2 == SRC_NONE);
        assign w_v1_nxt[i] = (w_s1 == SRC_ALU) ? cdb_alu_data :
                             (w_s1 == SRC_LSB) ? cdb_lsb_data : r_v1[i];
        assign w_v2_nxt[i] = (w_s2 == SRC_ALU) ? cdb_alu_data :
                             (w_s2 == SRC_LSB) ? cdb_lsb_data : r_v2[i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid   <= '0;
            r_q1_busy <= '0;
            r_q2_busy <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_op[i]  <= '0;
                r_imm[i] <= '0;
                r_pc[i]  <= '0;
                r_tag[i] <= '0;
                r_q1[i]  <= '0;
                r_q2[i]  <= '0;
                r_v1[i]  <= '0;
                r_v2[i]  <= '0;
            end
            r_op_o    <= '0;
            r_v1_o    <= '0;
            r_v2_o    <= '0;
            r_imm_o   <= '0;
            r_pc_o    <= '0;
            r_tag_o   <= '0;
            r_empty_o <= 1'b1;
        end else if (clear_from_rob) begin
            r_valid   <= '0;
            r_empty_o <= 1'b1;
        end else begin
            r_q1_busy <= w_q1_busy_nxt;
            r_q2_busy <= w_q2_busy_nxt;
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_v1[i] <= w_v1_nxt[i];
                r_v2[i] <= w_v2_nxt[i];
            end
            if (w_rdy_found) begin
                r_op_o           <= r_op[w_rdy_idx];
                r_v1_o           <= r_v1[w_rdy_idx];
                r_v2_o           <= r_v2[w_rdy_idx];
                r_imm_o          <= r_imm[w_rdy_idx];
                r_pc_o           <= r_pc[w_rdy_idx];
                r_tag_o          <= r_tag[w_rdy_idx];
                r_valid[w_rdy_idx] <= 1'b0;
                r_empty_o        <= 1'b0;
            end else begin
                r_empty_o <= 1'b1;
            end
            // A free slot is never the ready slot, so these writes cannot collide with issue.
            if (w_do_disp) begin
                r_valid[w_free_idx]   <= 1'b1;
                r_op[w_free_idx]      <= dispatch_op;
                r_imm[w_free_idx]     <= dispatch_imm;
                r_pc[w_free_idx]      <= dispatch_pc;
                r_tag[w_free_idx]     <= dispatch_tag;
                r_q1[w_free_idx]      <= dispatch_q1;
                r_q2[w_free_idx]      <= dispatch_q2;
                r_q1_busy[w_free_idx] <= w_d_q1_busy;
                r_q2_busy[w_free_idx] <= w_d_q2_busy;
                r_v1[w_free_idx]      <= w_d_v1;
                r_v2[w_free_idx]      <= w_d_v2;
            end
        end
    end

    assign full_to_dispatch = w_full;
    assign op_to_alu        = r_op_o;
    assign v1_to_alu        = r_v1_o;
    assign v2_to_alu        = r_v2_o;
    assign imm_to_alu       = r_imm_o;
    assign pc_to_alu        = r_pc_o;
    assign tag_to_rob       = r_tag_o;
    assign is_empty_to_alu  = r_empty_o;

endmodule
